fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Two-requester write arbiter and pointer/count control for a FIFO built on an external memory.
// Define FIFO_ARB_LOCK_EN to let a streaming winner keep the grant while its valid stays high.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned ADDRESS_SIZE = 3
) (
  input  logic                    write_clk,
  input  logic                    write_rst_n,
  input  logic                    req0_valid,
  input  logic [DATA_SIZE-1:0]    req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [DATA_SIZE-1:0]    req1_data,
  output logic                    req1_ready,
  input  logic                    rd_en,
  output logic [DATA_SIZE-1:0]    write_data,
  output logic [ADDRESS_SIZE-1:0] write_address,
  output logic                    write_clk_en,
  output logic                    write_full,
  output logic [ADDRESS_SIZE-1:0] read_address,
  output logic                    empty,
  output logic [ADDRESS_SIZE:0]   count,
  output logic [1:0]              grant
);

  localparam logic [ADDRESS_SIZE:0] Depth = {1'b1, {ADDRESS_SIZE{1'b0}}};
  localparam logic [ADDRESS_SIZE:0] One   = {{ADDRESS_SIZE{1'b0}}, 1'b1};

  logic [ADDRESS_SIZE:0] wptr_q, wptr_d;
  logic [ADDRESS_SIZE:0] rptr_q, rptr_d;
  logic [ADDRESS_SIZE:0] count_q, count_d;
  logic                  last_grant_q, last_grant_d;  // 1: req1 won the most recent write
`ifdef FIFO_ARB_LOCK_EN
  logic                  lock_q, lock_d;
`endif

  logic       full_s;
  logic       empty_s;
  logic       do_write;
  logic       do_pop;
  logic [1:0] rr_grant;
  logic [1:0] grant_s;

  assign full_s  = (count_q == Depth);
  assign empty_s = (count_q == '0);

  // Round-robin pick; grant is also forced off while reset is held so nothing leaks out.
  always_comb begin
    rr_grant = 2'b00;
    if (req0_valid && req1_valid) begin
      rr_grant = last_grant_q ? 2'b01 : 2'b10;
    end else if (req0_valid) begin
      rr_grant = 2'b01;
    end else if (req1_valid) begin
      rr_grant = 2'b10;
    end

    grant_s = 2'b00;
    if (write_rst_n && !full_s) begin
      grant_s = rr_grant;
`ifdef FIFO_ARB_LOCK_EN
      if (lock_q && !last_grant_q && req0_valid) grant_s = 2'b01;
      if (lock_q &&  last_grant_q && req1_valid) grant_s = 2'b10;
`endif
    end
  end

  assign do_write = |grant_s;
  assign do_pop   = rd_en && !empty_s;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    if (do_write) begin
      wptr_d       = wptr_q + One;
      last_grant_d = grant_s[1];
    end
    if (do_pop) begin
      rptr_d = rptr_q + One;
    end
    unique case ({do_write, do_pop})
      2'b10:   count_d = count_q + One;
      2'b01:   count_d = count_q - One;
      default: count_d = count_q;
    endcase
  end

`ifdef FIFO_ARB_LOCK_EN
  // The lock follows last_grant; it lapses on any cycle without an accepted write.
  always_comb begin
    lock_d = do_write;
  end

  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`endif

  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign grant         = grant_s;
  assign req0_ready    = grant_s[0];
  assign req1_ready    = grant_s[1];
  assign write_clk_en  = do_write;
  assign write_data    = grant_s[1] ? req1_data : req0_data;
  assign write_address = wptr_q[ADDRESS_SIZE-1:0];
  assign read_address  = rptr_q[ADDRESS_SIZE-1:0];
  assign write_full    = full_s;
  assign empty         = empty_s;
  assign count         = count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus queues expected writes/reads, a monitor
// compares them when the DUT strobes memory or pops. Build with FIFO_ARB_LOCK_EN for lock mode.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic          rd_en = 1'b0;
  logic [DW-1:0] write_data;
  logic [AW-1:0] write_address;
  logic          write_clk_en;
  logic          write_full;
  logic [AW-1:0] read_address;
  logic          empty;
  logic [AW:0]   count;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_SIZE(DW), .ADDRESS_SIZE(AW)) dut (
    .write_clk    (clk),
    .write_rst_n  (rst_n),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .rd_en        (rd_en),
    .write_data   (write_data),
    .write_address(write_address),
    .write_clk_en (write_clk_en),
    .write_full   (write_full),
    .read_address (read_address),
    .empty        (empty),
    .count        (count),
    .grant        (grant)
  );

  typedef struct packed {
    logic [1:0]    g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wr_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] mem [8];
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model written by the DUT strobe, read back by the monitor on pops.
  always @(posedge clk) begin
    if (write_clk_en) mem[write_address] <= write_data;
  end

  always @(negedge clk) begin
    wr_t e;
    logic [DW-1:0] r;
    if (rst_n && write_clk_en) begin
      if (wr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h at addr %0h, required no write (t=%0t)",
                 write_data, write_address, $time);
      end else begin
        e = wr_q.pop_front();
        check("wr_grant", 32'(grant), 32'(e.g));
        check("wr_ready", 32'({req1_ready, req0_ready}), 32'(e.g));
        check("wr_addr", 32'(write_address), 32'(e.a));
        check("wr_data", 32'(write_data), 32'(e.d));
      end
    end
    if (rst_n && rd_en && !empty) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got pop at addr %0h, required no pop (t=%0t)",
                 read_address, $time);
      end else begin
        r = rd_q.pop_front();
        check("rd_data", 32'(mem[read_address]), 32'(r));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [DW-1:0] d0, input logic v1,
                       input logic [DW-1:0] d1, input logic re);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    rd_en      = re;
  endtask

  task automatic exp_wr(input logic [1:0] g, input int a, input logic [DW-1:0] d);
    wr_t e;
    e.g = g;
    e.a = AW'(a);
    e.d = d;
    wr_q.push_back(e);
  endtask

  task automatic status(input string tag, input int c, input logic e, input logic f,
                        input int wa, input int ra);
    @(negedge clk);
    check({tag, "_count"}, 32'(count), c);
    check({tag, "_empty"}, 32'(empty), 32'(e));
    check({tag, "_full"}, 32'(write_full), 32'(f));
    check({tag, "_waddr"}, 32'(write_address), wa);
    check({tag, "_raddr"}, 32'(read_address), ra);
  endtask

  // Assert reset mid-cycle, check the immediate effect, release away from the clock edge.
  task automatic rst_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_count"}, 32'(count), 0);
    check({tag, "_rst_empty"}, 32'(empty), 1);
    check({tag, "_rst_grant"}, 32'(grant), 0);
    check({tag, "_rst_wen"}, 32'(write_clk_en), 0);
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  logic [1:0]    f_g [4];
  logic [DW-1:0] f_wd[4];
  logic [DW-1:0] f_d0[4];
  logic [DW-1:0] f_d1[4];
  logic          f_v1[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
    $fatal(1);
  end

  initial begin
    // Power-on reset with a requester already valid: nothing may be granted.
    req0_valid = 1'b1;
    req0_data  = 8'hEE;
    @(posedge clk);
    #1;
    check("por_grant", 32'(grant), 0);
    check("por_wen", 32'(write_clk_en), 0);
    check("por_ready0", 32'(req0_ready), 0);
    check("por_count", 32'(count), 0);
    check("por_empty", 32'(empty), 1);
    check("por_full", 32'(write_full), 0);
    check("por_addr", 32'({write_address, read_address}), 0);
    @(negedge clk);
    #1;
    req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single write then pop.
    drive(1'b1, 8'hA5, 1'b0, '0, 1'b0);
    exp_wr(2'b01, 0, 8'hA5);
    status("a_wr", 0, 1'b1, 1'b0, 0, 0);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    rd_q.push_back(8'hA5);
    status("a_pop", 1, 1'b0, 1'b0, 1, 0);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    status("a_idle", 0, 1'b1, 1'b0, 1, 1);
    tick();

    // Contention from reset: req1 first, then alternating.
    rst_pulse("b");
    begin
      logic [DW-1:0] bd0[4] = '{8'h10, 8'h10, 8'h11, 8'h11};
      logic [DW-1:0] bd1[4] = '{8'h20, 8'h21, 8'h21, 8'h22};
      logic [1:0]    bg [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
      logic [DW-1:0] bwd[4] = '{8'h20, 8'h10, 8'h21, 8'h11};
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, bd0[i], 1'b1, bd1[i], 1'b0);
        exp_wr(bg[i], i, bwd[i]);
        status("b_wr", i, i == 0, 1'b0, i, 0);
        tick();
      end
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        rd_q.push_back(bwd[i]);
        status("b_pop", 4 - i, 1'b0, 1'b0, 4, i);
        tick();
      end
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    status("b_idle", 0, 1'b1, 1'b0, 4, 4);
    tick();

    // Fill to full, blocked write, pop, then the held write lands at address 0.
    rst_pulse("c");
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0, '0, 1'b0);
      exp_wr(2'b01, i, 8'(8'h30 + i));
      status("c_fill", i, i == 0, 1'b0, i, 0);
      tick();
    end
    drive(1'b1, 8'h40, 1'b0, '0, 1'b0);
    status("c_full", 8, 1'b0, 1'b1, 0, 0);
    check("c_full_ready0", 32'(req0_ready), 0);
    check("c_full_wen", 32'(write_clk_en), 0);
    check("c_full_grant", 32'(grant), 0);
    check("c_full_wdata", 32'(write_data), 32'h40);
    tick();
    drive(1'b1, 8'h40, 1'b0, '0, 1'b1);
    rd_q.push_back(8'h30);
    status("c_fullpop", 8, 1'b0, 1'b1, 0, 0);
    check("c_fullpop_grant", 32'(grant), 0);
    tick();
    drive(1'b1, 8'h40, 1'b0, '0, 1'b0);
    exp_wr(2'b01, 0, 8'h40);
    status("c_refill", 7, 1'b0, 1'b0, 0, 1);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    status("c_again", 8, 1'b0, 1'b1, 1, 1);
    tick();

    // Simultaneous write and pop at count 3, then pop while empty.
    rst_pulse("d");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 8'(8'h50 + i), 1'b0);
      exp_wr(2'b10, i, 8'(8'h50 + i));
      status("d_fill", i, i == 0, 1'b0, i, 0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 8'h53, 1'b1);
    exp_wr(2'b10, 3, 8'h53);
    rd_q.push_back(8'h50);
    status("d_both", 3, 1'b0, 1'b0, 3, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      rd_q.push_back(8'(8'h51 + k));
      status("d_pop", 3 - k, 1'b0, 1'b0, 4, 1 + k);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    status("d_empty_rd", 0, 1'b1, 1'b0, 4, 4);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    status("d_after", 0, 1'b1, 1'b0, 4, 4);
    tick();

    // 20 writes with pops interleaved: pointers wrap, count stays bounded.
    rst_pulse("e");
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'h60 + i), 1'b0, '0, i >= 5);
      exp_wr(2'b01, i % 8, 8'(8'h60 + i));
      if (i >= 5) rd_q.push_back(8'(8'h60 + i - 5));
      status("e_wrap", (i < 5) ? i : 5, i == 0, 1'b0, i % 8, (i < 5) ? 0 : (i - 5) % 8);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      rd_q.push_back(8'(8'h60 + 15 + k));
      status("e_drain", 5 - k, 1'b0, 1'b0, 4, (15 + k) % 8);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    status("e_idle", 0, 1'b1, 1'b0, 4, 4);
    tick();

    // Three contended beats, then req1 drops; expectation depends on the lock build.
`ifdef FIFO_ARB_LOCK_EN
    f_d0 = '{8'h80, 8'h80, 8'h80, 8'h80};
    f_d1 = '{8'h90, 8'h91, 8'h92, 8'h00};
    f_v1 = '{1'b1, 1'b1, 1'b1, 1'b0};
    f_g  = '{2'b10, 2'b10, 2'b10, 2'b01};
    f_wd = '{8'h90, 8'h91, 8'h92, 8'h80};
`else
    f_d0 = '{8'h80, 8'h80, 8'h81, 8'h81};
    f_d1 = '{8'h90, 8'h91, 8'h91, 8'h00};
    f_v1 = '{1'b1, 1'b1, 1'b1, 1'b0};
    f_g  = '{2'b10, 2'b01, 2'b10, 2'b01};
    f_wd = '{8'h90, 8'h80, 8'h91, 8'h81};
`endif
    rst_pulse("f");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, f_d0[i], f_v1[i], f_d1[i], 1'b0);
      exp_wr(f_g[i], i, f_wd[i]);
      status("f_arb", i, i == 0, 1'b0, i, 0);
      tick();
    end
    // Mid-stream reset with both requesters still valid.
    drive(1'b1, 8'h85, 1'b1, 8'h95, 1'b0);
    rst_pulse("f_mid");
    drive(1'b1, 8'hA0, 1'b0, '0, 1'b0);
    exp_wr(2'b01, 0, 8'hA0);
    status("f_post", 0, 1'b1, 1'b0, 0, 0);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    status("f_end", 1, 1'b0, 1'b0, 1, 0);
    tick();

    check("sb_wr_left", 32'(wr_q.size()), 0);
    check("sb_rd_left", 32'(rd_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
